// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer for a shared combinational ALU.
//
// Collects operand A, an operator and operand B from a single-key-per-event
// keypad stream. On '=' it holds the ALU inputs steady for one settle cycle
// (EXEC), then latches the ALU result and flags for the display (SHOW).
//
// Ports:
//   clk                         system clock, rising edge
//   rst_n                       synchronous active-low reset
//   key_valid, key_code[3:0]    keypad event: 0-7 digit, 8 add, 9 sub, 10 mul,
//                               11 rem, 12 equals, 13 clear, 14-15 ignored
//   alu_a[2:0], alu_b[2:0]      operands driven to the ALU
//   alu_s[1:0]                  ALU opcode: 00 add, 01 sub, 10 mul, 11 rem
//   alu_r[3:0], alu_sf/zf/dzf   ALU result and sign/zero/divide-by-zero flags
//   res[3:0], res_sf/zf/dzf     latched result and flags
//   res_valid                   high while the result is shown
//   key_err                     one-cycle pulse on a key illegal in this state
//   state[2:0]                  encoded state for display/debug
//
// Parameters:
//   SHOW_TIMEOUT  cycles SHOW holds before returning to IDLE (0 = forever)
//   CNT_W         timeout counter width; SHOW_TIMEOUT must be < 2**CNT_W
module calc_sequencer #(
  parameter int unsigned SHOW_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_s,
  input  logic [3:0] alu_r,
  input  logic       alu_sf,
  input  logic       alu_zf,
  input  logic       alu_dzf,
  output logic [3:0] res,
  output logic       res_sf,
  output logic       res_zf,
  output logic       res_dzf,
  output logic       res_valid,
  output logic       key_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGotA  = 3'd1,
    StGotOp = 3'd2,
    StGotB  = 3'd3,
    StExec  = 3'd4,
    StShow  = 3'd5
  } stateT;

  // Count value on the last SHOW cycle before auto-return.
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(SHOW_TIMEOUT - 1);

  stateT             stateQ, stateD;
  logic [2:0]        aQ, aD, bQ, bD;
  logic [1:0]        sQ, sD;
  logic [3:0]        resQ, resD;
  logic              sfQ, sfD, zfQ, zfD, dzfQ, dzfD;
  logic              keyErrQ, keyErrD;
  logic [CNT_W-1:0]  cntQ, cntD;

  logic isDigit, isOp, isEq, isClr, doClear;

  always_comb begin
    isDigit = (key_code[3] == 1'b0);
    isOp    = (key_code[3:2] == 2'b10);
    isEq    = (key_code == 4'd12);
    isClr   = (key_code == 4'd13);
  end

  always_comb begin
    stateD  = stateQ;
    aD      = aQ;
    bD      = bQ;
    sD      = sQ;
    resD    = resQ;
    sfD     = sfQ;
    zfD     = zfQ;
    dzfD    = dzfQ;
    keyErrD = 1'b0;
    cntD    = cntQ;
    doClear = 1'b0;

    if (stateQ == StExec) begin
      // Settle cycle: keys are ignored, ALU inputs held, result captured.
      resD   = alu_r;
      sfD    = alu_sf;
      zfD    = alu_zf;
      dzfD   = alu_dzf;
      cntD   = '0;
      stateD = StShow;
    end else if (key_valid && isClr) begin
      doClear = 1'b1;
    end else begin
      case (stateQ)
        StIdle: begin
          if (key_valid && isDigit) begin
            aD     = key_code[2:0];
            stateD = StGotA;
          end else if (key_valid && (isOp || isEq)) begin
            keyErrD = 1'b1;
          end
        end
        StGotA: begin
          if (key_valid && isDigit) begin
            aD = key_code[2:0];
          end else if (key_valid && isOp) begin
            sD     = key_code[1:0];
            stateD = StGotOp;
          end else if (key_valid && isEq) begin
            keyErrD = 1'b1;
          end
        end
        StGotOp: begin
          if (key_valid && isOp) begin
            sD = key_code[1:0];
          end else if (key_valid && isDigit) begin
            bD     = key_code[2:0];
            stateD = StGotB;
          end else if (key_valid && isEq) begin
            keyErrD = 1'b1;
          end
        end
        StGotB: begin
          if (key_valid && isDigit) begin
            bD = key_code[2:0];
          end else if (key_valid && isOp) begin
            keyErrD = 1'b1;
          end else if (key_valid && isEq) begin
            stateD = StExec;
          end
        end
        StShow: begin
          if (key_valid && isDigit) begin
            // Start a fresh calculation; res and flags persist until next EXEC.
            aD     = key_code[2:0];
            bD     = '0;
            sD     = '0;
            cntD   = '0;
            stateD = StGotA;
          end else begin
            // Chaining is unsupported: a 4-bit result cannot feed a 3-bit operand.
            if (key_valid && (isOp || isEq)) begin
              keyErrD = 1'b1;
            end
            if (SHOW_TIMEOUT != 0) begin
              if (cntQ == TimeoutLast) begin
                doClear = 1'b1;
              end else begin
                cntD = cntQ + CNT_W'(1);
              end
            end
          end
        end
        default: stateD = StIdle;
      endcase
    end

    if (doClear) begin
      stateD = StIdle;
      aD     = '0;
      bD     = '0;
      sD     = '0;
      resD   = '0;
      sfD    = 1'b0;
      zfD    = 1'b0;
      dzfD   = 1'b0;
      cntD   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      aQ      <= '0;
      bQ      <= '0;
      sQ      <= '0;
      resQ    <= '0;
      sfQ     <= 1'b0;
      zfQ     <= 1'b0;
      dzfQ    <= 1'b0;
      keyErrQ <= 1'b0;
      cntQ    <= '0;
    end else begin
      stateQ  <= stateD;
      aQ      <= aD;
      bQ      <= bD;
      sQ      <= sD;
      resQ    <= resD;
      sfQ     <= sfD;
      zfQ     <= zfD;
      dzfQ    <= dzfD;
      keyErrQ <= keyErrD;
      cntQ    <= cntD;
    end
  end

  assign alu_a     = aQ;
  assign alu_b     = bQ;
  assign alu_s     = sQ;
  assign res       = resQ;
  assign res_sf    = sfQ;
  assign res_zf    = zfQ;
  assign res_dzf   = dzfQ;
  assign res_valid = (stateQ == StShow);
  assign key_err   = keyErrQ;
  assign state     = stateQ;

endmodule
